// File: rtl/cpu_types_pkg.sv
// Shared datapath/cache types: the 32-bit machine word used across the request protocol.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/word_ram.sv
// Synchronous single-port word RAM: read data appears one edge after en; writes take the same edge.
// No backpressure; one access per enabled cycle, contents untouched by reset.
module word_ram
    import cpu_types_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter     INIT_FILE = "",
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          en,
    input  logic          wen,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    word_t mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (en) begin
            if (wen) begin
                mem[idx] <= wdata;
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Cache stand-in: serves one imem/dmem request at a time, hit LAT+1 cycles after the request is sampled.
// Data beats instruction in arbitration; dropping the pending enable during WAIT aborts the request.
module mem_responder
    import cpu_types_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int LAT       = 2,
    parameter     INIT_FILE = ""
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {IFETCH, DREAD, DWRITE} kind_t;

    state_t        state_q, state_d;
    kind_t         kind_q, kind_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    word_t         store_q, store_d;
    word_t         iload_q, dload_q;

    logic          req;
    kind_t         req_kind;
    logic [AW-1:0] req_idx;
    logic          kind_en;

    logic          access;
    kind_t         ram_kind;
    logic [AW-1:0] ram_idx;
    word_t         ram_wdata;
    word_t         ram_rdata;
    logic          ram_en;
    logic          ram_wen;

    logic          unused_addr_bits;
    assign unused_addr_bits = ^{imemaddr[31:AW+2], imemaddr[1:0],
                                dmemaddr[31:AW+2], dmemaddr[1:0]};

    // Both data enables high counts as a write.
    assign req      = imemREN | dmemREN | dmemWEN;
    assign req_kind = dmemWEN ? DWRITE : (dmemREN ? DREAD : IFETCH);
    assign req_idx  = (dmemWEN | dmemREN) ? dmemaddr[AW+1:2] : imemaddr[AW+1:2];

    always_comb begin
        kind_en = 1'b0;
        case (kind_q)
            IFETCH:  kind_en = imemREN;
            DREAD:   kind_en = dmemREN;
            DWRITE:  kind_en = dmemWEN;
            default: kind_en = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            kind_q  <= IFETCH;
            cnt_q   <= '0;
            idx_q   <= '0;
            store_q <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            store_q <= store_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        store_d   = store_q;
        access    = 1'b0;
        ram_kind  = kind_q;
        ram_idx   = idx_q;
        ram_wdata = store_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    kind_d  = req_kind;
                    idx_d   = req_idx;
                    store_d = dmemstore;
                    // With no latency the access uses the live request, not the latch.
                    if (LAT == 0) begin
                        state_d   = RESP;
                        access    = 1'b1;
                        ram_kind  = req_kind;
                        ram_idx   = req_idx;
                        ram_wdata = dmemstore;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(LAT);
                    end
                end
            end
            WAIT: begin
                if (!kind_en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gate with reset so a request held through reset never touches the RAM.
    assign ram_en  = access & nRST;
    assign ram_wen = ram_en & (ram_kind == DWRITE);

    word_ram #(
        .DEPTH    (DEPTH),
        .INIT_FILE(INIT_FILE)
    ) u_ram (
        .CLK  (CLK),
        .en   (ram_en),
        .wen  (ram_wen),
        .idx  (ram_idx),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // RAM output is live during RESP; the load registers keep it afterwards.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            iload_q <= '0;
            dload_q <= '0;
        end else if (state_q == RESP) begin
            if (kind_q == IFETCH) begin
                iload_q <= ram_rdata;
            end
            if (kind_q == DREAD) begin
                dload_q <= ram_rdata;
            end
        end
    end

    assign ihit     = (state_q == RESP) && (kind_q == IFETCH);
    assign dhit     = (state_q == RESP) && (kind_q != IFETCH);
    assign imemload = ((state_q == RESP) && (kind_q == IFETCH)) ? ram_rdata : iload_q;
    assign dmemload = ((state_q == RESP) && (kind_q == DREAD))  ? ram_rdata : dload_q;

endmodule
